// File: rtl/tribus_arbiter2.sv
// Round-robin arbiter/sequencer for a two-master tristate 2:1 mux bus.
// Bounds ownership while the other master waits and forces a bus-off turnaround between grants.
module tribus_arbiter2 #(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       e,
    output logic       s,
    output logic       preempt
);

    localparam int unsigned CW = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2,
        TURN = 2'd3
    } state_t;

    state_t        state;
    state_t        state_n;
    logic          last;
    logic          last_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [1:0]    gnt_n;
    logic          e_n;
    logic          s_n;
    logic          preempt_n;

    // Round-robin pick: on a tie the requester that did not own last wins.
    function automatic state_t pick(input logic [1:0] r, input logic l);
        state_t p;
        case (r)
            2'b11:   p = l ? OWN0 : OWN1;
            2'b01:   p = OWN0;
            2'b10:   p = OWN1;
            default: p = IDLE;
        endcase
        return p;
    endfunction

    // Next-state and next-output decode.
    always_comb begin
        state_n   = state;
        last_n    = last;
        cnt_n     = cnt;
        preempt_n = 1'b0;
        gnt_n     = 2'b00;
        e_n       = 1'b0;
        s_n       = s;

        unique case (state)
            IDLE, TURN: begin
                state_n = pick(req, last);
                if (state_n == OWN0) begin
                    last_n = 1'b0;
                    cnt_n  = '0;
                end else if (state_n == OWN1) begin
                    last_n = 1'b1;
                    cnt_n  = '0;
                end
            end
            OWN0: begin
                if (!req[0]) begin
                    state_n = TURN;
                end else if (req[1] && (cnt == CNT_MAX)) begin
                    state_n   = TURN;
                    preempt_n = 1'b1;
                end else if (cnt != CNT_MAX) begin
                    cnt_n = cnt + CW'(1);
                end
            end
            OWN1: begin
                if (!req[1]) begin
                    state_n = TURN;
                end else if (req[0] && (cnt == CNT_MAX)) begin
                    state_n   = TURN;
                    preempt_n = 1'b1;
                end else if (cnt != CNT_MAX) begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // Outputs are a pure decode of the state being entered; s keeps its value off-bus.
        if (state_n == OWN0) begin
            gnt_n = 2'b01;
            e_n   = 1'b1;
            s_n   = 1'b0;
        end else if (state_n == OWN1) begin
            gnt_n = 2'b10;
            e_n   = 1'b1;
            s_n   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            last    <= 1'b1;
            cnt     <= '0;
            gnt     <= 2'b00;
            e       <= 1'b0;
            s       <= 1'b0;
            preempt <= 1'b0;
        end else begin
            state   <= state_n;
            last    <= last_n;
            cnt     <= cnt_n;
            gnt     <= gnt_n;
            e       <= e_n;
            s       <= s_n;
            preempt <= preempt_n;
        end
    end

endmodule

// File: tb/tb_tribus_arbiter2.sv
// Scoreboard bench for tribus_arbiter2: stimulus pushes expected outputs per cycle, a monitor pops and compares.
module tb_tribus_arbiter2;

    typedef struct packed {
        int unsigned cyc;
        logic [1:0]  gnt;
        logic        e;
        logic        s;
        logic        pre;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req = 2'b11;
    logic [1:0] gnt;
    logic       e;
    logic       s;
    logic       preempt;

    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    exp_t        exp_q[$];
    string       name_q[$];

    tribus_arbiter2 #(.HOLD_MAX(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .e       (e),
        .s       (s),
        .preempt (preempt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Drive req, record what the outputs must be after the coming edge, then advance past it.
    task automatic step(input logic [1:0] r, input logic [1:0] g, input logic es,
                        input logic pre, input string nm);
        exp_t x;
        req   = r;
        x.cyc = cyc + 1;
        x.gnt = g;
        x.e   = |g;
        x.s   = es;
        x.pre = pre;
        exp_q.push_back(x);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // Monitor: samples after the falling clock edge and right after any reset assertion.
    initial begin : monitor
        exp_t  x;
        string nm;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            if (!rst_n) begin
                n_chk++;
                if ({gnt, e, s, preempt} !== 5'b0) begin
                    n_fail++;
                    $display("FAIL reset_outputs: got gnt=%b e=%b s=%b preempt=%b, want all 0",
                             gnt, e, s, preempt);
                end
            end else begin
                n_chk++;
                if ((e !== |gnt) || (gnt === 2'b11)) begin
                    n_fail++;
                    $display("FAIL invariant cyc %0d: gnt=%b e=%b", cyc, gnt, e);
                end
                while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    x  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    n_chk++;
                    if (x.cyc < cyc) begin
                        n_fail++;
                        $display("FAIL %s: expectation for cyc %0d never sampled (now %0d)",
                                 nm, x.cyc, cyc);
                    end else if ({gnt, e, s, preempt} !== {x.gnt, x.e, x.s, x.pre}) begin
                        n_fail++;
                        $display("FAIL %s cyc %0d: got gnt=%b e=%b s=%b preempt=%b, want gnt=%b e=%b s=%b preempt=%b",
                                 nm, cyc, gnt, e, s, preempt, x.gnt, x.e, x.s, x.pre);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Tie from reset goes to requester 0, then HOLD_MAX preemption both ways.
        step(2'b11, 2'b01, 1'b0, 1'b0, "rst_release");
        repeat (3) step(2'b11, 2'b01, 1'b0, 1'b0, "pre_own0");
        step(2'b11, 2'b00, 1'b0, 1'b1, "pre_turn0");
        repeat (4) step(2'b11, 2'b10, 1'b1, 1'b0, "pre_own1");
        step(2'b11, 2'b00, 1'b1, 1'b1, "pre_turn1");
        step(2'b11, 2'b01, 1'b0, 1'b0, "pre_back0");

        // Owner 0 releases with requester 1 waiting.
        step(2'b10, 2'b00, 1'b0, 1'b0, "rel_turn");
        step(2'b10, 2'b10, 1'b1, 1'b0, "rel_own1");

        // Lone long holder saturates, then a late waiter preempts on the next edge.
        repeat (19) step(2'b10, 2'b10, 1'b1, 1'b0, "lone_hold");
        step(2'b11, 2'b00, 1'b1, 1'b1, "lone_preempt");
        step(2'b11, 2'b01, 1'b0, 1'b0, "lone_next0");
        step(2'b00, 2'b00, 1'b0, 1'b0, "idle_turn");
        step(2'b00, 2'b00, 1'b0, 1'b0, "idle");

        // Single requester for three cycles.
        repeat (3) step(2'b01, 2'b01, 1'b0, 1'b0, "single");
        step(2'b00, 2'b00, 1'b0, 1'b0, "single_turn");
        step(2'b00, 2'b00, 1'b0, 1'b0, "single_idle");

        // Preempted owner is re-granted when the waiter withdraws during TURN; s holds off-bus.
        repeat (4) step(2'b10, 2'b10, 1'b1, 1'b0, "regrant_own1");
        step(2'b11, 2'b00, 1'b1, 1'b1, "regrant_turn");
        step(2'b10, 2'b10, 1'b1, 1'b0, "regrant_lone");
        step(2'b00, 2'b00, 1'b1, 1'b0, "hold_s_turn");
        step(2'b00, 2'b00, 1'b1, 1'b0, "hold_s_idle");

        // Asynchronous reset pulse in OWN1 between edges.
        step(2'b10, 2'b10, 1'b1, 1'b0, "arst_own1");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #2;
        req   = 2'b11;
        rst_n = 1'b1;
        step(2'b11, 2'b01, 1'b0, 1'b0, "arst_first");
        step(2'b00, 2'b00, 1'b0, 1'b0, "end_turn");

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
